// File: rtl/stereo_sample_sequencer.sv
// Sample-rate divider plus L/R holding registers that feed one shared engine
// over valid/ready, strictly left then right, with a sticky overrun flag.
module stereo_sample_sequencer #(
   parameter int DATA_W = 24,
   parameter int DIV_W  = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [2:0]        rate_sel,
   output logic              smp_tick,
   input  logic              l_in_valid,
   input  logic [DATA_W-1:0] l_in_data,
   input  logic              r_in_valid,
   input  logic [DATA_W-1:0] r_in_data,
   output logic              eng_valid,
   output logic [DATA_W-1:0] eng_data,
   output logic              eng_chan,
   input  logic              eng_ready,
   output logic              frame_done,
   output logic              overrun,
   input  logic              ovr_clear
);

   typedef enum logic [1:0] {
      WAIT_L,
      SEND_L,
      WAIT_R,
      SEND_R
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]  term_q, term_d;
   logic [DIV_W-1:0]  term_sel;
   logic              wrap;
   logic [DATA_W-1:0] l_hold_q, l_hold_d;
   logic [DATA_W-1:0] r_hold_q, r_hold_d;
   logic              l_full_q, l_full_d;
   logic              r_full_q, r_full_d;
   logic              eng_valid_q, eng_valid_d;
   logic [DATA_W-1:0] eng_data_q, eng_data_d;
   logic              eng_chan_q, eng_chan_d;
   logic              frame_done_q, frame_done_d;
   logic              overrun_q, overrun_d;
   logic              move_l, move_r;
   logic              ovr_set;

   // Terminal count (N-1) for each rate code; unused codes fall back to 48 kHz.
   always_comb begin
      case (rate_sel)
         3'd0:    term_sel = DIV_W'(255);
         3'd1:    term_sel = DIV_W'(511);
         3'd2:    term_sel = DIV_W'(1023);
         3'd3:    term_sel = DIV_W'(556);
         3'd4:    term_sel = DIV_W'(1114);
         default: term_sel = DIV_W'(1023);
      endcase
   end

   assign wrap     = run && (cnt_q == term_q);
   assign smp_tick = wrap;

   // The period length is only re-latched at a wrap, so a rate change lets the current period finish.
   always_comb begin
      cnt_d  = cnt_q;
      term_d = term_q;
      if (!run || wrap) begin
         cnt_d  = '0;
         term_d = term_sel;
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   always_comb begin
      state_d      = state_q;
      l_hold_d     = l_hold_q;
      r_hold_d     = r_hold_q;
      l_full_d     = l_full_q;
      r_full_d     = r_full_q;
      eng_data_d   = eng_data_q;
      eng_chan_d   = eng_chan_q;
      frame_done_d = 1'b0;
      move_l       = 1'b0;
      move_r       = 1'b0;
      ovr_set      = 1'b0;
      if (!run) begin
         state_d  = WAIT_L;
         l_full_d = 1'b0;
         r_full_d = 1'b0;
      end else begin
         case (state_q)
            WAIT_L: begin
               if (l_full_q) begin
                  state_d    = SEND_L;
                  move_l     = 1'b1;
                  eng_data_d = l_hold_q;
                  eng_chan_d = 1'b0;
               end
            end
            SEND_L: begin
               if (eng_ready) begin
                  state_d = WAIT_R;
               end
            end
            WAIT_R: begin
               if (r_full_q) begin
                  state_d    = SEND_R;
                  move_r     = 1'b1;
                  eng_data_d = r_hold_q;
                  eng_chan_d = 1'b1;
               end
            end
            SEND_R: begin
               if (eng_ready) begin
                  state_d      = WAIT_L;
                  frame_done_d = 1'b1;
               end
            end
            default: state_d = WAIT_L;
         endcase

         // A capture on the same edge as the move refills the hold without counting as an overrun.
         if (move_l) begin
            l_full_d = 1'b0;
         end
         if (l_in_valid) begin
            l_hold_d = l_in_data;
            l_full_d = 1'b1;
            if (l_full_q && !move_l) begin
               ovr_set = 1'b1;
            end
         end
         if (move_r) begin
            r_full_d = 1'b0;
         end
         if (r_in_valid) begin
            r_hold_d = r_in_data;
            r_full_d = 1'b1;
            if (r_full_q && !move_r) begin
               ovr_set = 1'b1;
            end
         end
      end

      eng_valid_d = (state_d == SEND_L) || (state_d == SEND_R);

      overrun_d = overrun_q;
      if (ovr_set) begin
         overrun_d = 1'b1;
      end else if (ovr_clear) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= WAIT_L;
         cnt_q        <= '0;
         term_q       <= DIV_W'(1023);
         l_hold_q     <= '0;
         r_hold_q     <= '0;
         l_full_q     <= 1'b0;
         r_full_q     <= 1'b0;
         eng_valid_q  <= 1'b0;
         eng_data_q   <= '0;
         eng_chan_q   <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         term_q       <= term_d;
         l_hold_q     <= l_hold_d;
         r_hold_q     <= r_hold_d;
         l_full_q     <= l_full_d;
         r_full_q     <= r_full_d;
         eng_valid_q  <= eng_valid_d;
         eng_data_q   <= eng_data_d;
         eng_chan_q   <= eng_chan_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign eng_valid  = eng_valid_q;
   assign eng_data   = eng_data_q;
   assign eng_chan   = eng_chan_q;
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_stereo_sample_sequencer.sv
// Scoreboard bench for stereo_sample_sequencer: directed scenarios plus
// randomized frames checked by a negedge monitor against queued expectations.
module tb_stereo_sample_sequencer;

   localparam int DATA_W = 24;
   localparam int DIV_W  = 11;

   typedef struct packed {
      logic              chan;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              run;
   logic [2:0]        rate_sel;
   logic              smp_tick;
   logic              l_in_valid;
   logic [DATA_W-1:0] l_in_data;
   logic              r_in_valid;
   logic [DATA_W-1:0] r_in_data;
   logic              eng_valid;
   logic [DATA_W-1:0] eng_data;
   logic              eng_chan;
   logic              eng_ready;
   logic              frame_done;
   logic              overrun;
   logic              ovr_clear;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   tick_count = 0;
   bit   rand_ready = 1'b0;
   exp_t exp_q[$];

   // Monitor state
   exp_t              mon_e;
   bit                prev_rx = 1'b0;
   bit                prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data;
   logic              prev_chan;
   bit                armed = 1'b0;
   int                lat_n = 1024;
   int                next_at = 0;
   bit                exp_tick;

   stereo_sample_sequencer #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .rate_sel   (rate_sel),
      .smp_tick   (smp_tick),
      .l_in_valid (l_in_valid),
      .l_in_data  (l_in_data),
      .r_in_valid (r_in_valid),
      .r_in_data  (r_in_data),
      .eng_valid  (eng_valid),
      .eng_data   (eng_data),
      .eng_chan   (eng_chan),
      .eng_ready  (eng_ready),
      .frame_done (frame_done),
      .overrun    (overrun),
      .ovr_clear  (ovr_clear)
   );

   always #5 clk = ~clk;

   // Sample period in master clocks for each rate code.
   function automatic int nOf(input logic [2:0] r);
      case (r)
         3'd0:    return 256;
         3'd1:    return 512;
         3'd2:    return 1024;
         3'd3:    return 557;
         3'd4:    return 1115;
         default: return 1024;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
      if (rand_ready) begin
         eng_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic applyStimulus(input bit lv, input logic [DATA_W-1:0] ld,
                                input bit rv, input logic [DATA_W-1:0] rd);
      l_in_valid = lv;
      l_in_data  = ld;
      r_in_valid = rv;
      r_in_data  = rd;
      stepCycle();
      l_in_valid = 1'b0;
      r_in_valid = 1'b0;
   endtask

   task automatic pushExp(input logic chan, input logic [DATA_W-1:0] data);
      exp_t e;
      e.chan = chan;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic waitDrain(input string name, input int limit);
      int n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         stepCycle();
         n++;
      end
      checkOutput({name, "_drain"}, exp_q.size(), 0);
      stepCycle();
      stepCycle();
   endtask

   // Monitor: pops expected samples on every transfer, checks frame_done,
   // output stability under backpressure, and the sample-rate tick schedule.
   always @(negedge clk) begin
      cyc++;
      if (!reset && run && eng_valid && eng_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_xfer: got chan %0d data 0x%0h, expected no transfer", eng_chan, eng_data);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("xfer_chan", 32'(eng_chan), 32'(mon_e.chan));
            checkOutput("xfer_data", 32'(eng_data), 32'(mon_e.data));
         end
      end
      if (prev_rx || frame_done) begin
         checkOutput("frame_done", 32'(frame_done), 32'(prev_rx));
      end
      if (prev_stall && run && !reset) begin
         checkOutput("stall_valid", 32'(eng_valid), 1);
         checkOutput("stall_data", 32'(eng_data), 32'(prev_data));
         checkOutput("stall_chan", 32'(eng_chan), 32'(prev_chan));
      end
      prev_rx    = !reset && run && eng_valid && eng_ready && eng_chan;
      prev_stall = !reset && run && eng_valid && !eng_ready;
      prev_data  = eng_data;
      prev_chan  = eng_chan;

      // Tick schedule in absolute cycles: first tick N-1 cycles after run rises,
      // each later tick one period (chosen at the previous tick) further on.
      if (reset || !run) begin
         armed = 1'b0;
         lat_n = nOf(rate_sel);
      end else begin
         if (!armed) begin
            armed   = 1'b1;
            next_at = cyc + lat_n - 1;
         end
         exp_tick = (cyc == next_at);
         if (exp_tick || smp_tick) begin
            checkOutput("smp_tick", 32'(smp_tick), 32'(exp_tick));
         end
         if (smp_tick) begin
            tick_count++;
         end
         if (exp_tick) begin
            next_at = cyc + nOf(rate_sel);
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [DATA_W-1:0] ld, rd;
      int dl, dr, n;

      reset      = 1'b1;
      run        = 1'b0;
      rate_sel   = 3'd4;
      l_in_valid = 1'b0;
      l_in_data  = '0;
      r_in_valid = 1'b0;
      r_in_data  = '0;
      eng_ready  = 1'b0;
      ovr_clear  = 1'b0;
      repeat (3) stepCycle();
      reset = 1'b0;
      repeat (2) stepCycle();

      // Reset values
      checkOutput("rst_smp_tick", 32'(smp_tick), 0);
      checkOutput("rst_eng_valid", 32'(eng_valid), 0);
      checkOutput("rst_eng_data", 32'(eng_data), 0);
      checkOutput("rst_eng_chan", 32'(eng_chan), 0);
      checkOutput("rst_frame_done", 32'(frame_done), 0);
      checkOutput("rst_overrun", 32'(overrun), 0);

      // Tick period at 44.1 kHz, then a mid-period switch to 192 kHz
      tick_count = 0;
      run = 1'b1;
      for (int i = 0; i < 2750; i++) begin
         stepCycle();
         if (i == 1500) rate_sel = 3'd0;
      end
      run = 1'b0;
      checkOutput("tick_count", tick_count, 4);
      stepCycle();

      // Basic frame with the engine always ready
      run       = 1'b1;
      eng_ready = 1'b1;
      repeat (2) stepCycle();
      pushExp(1'b0, 24'h123456);
      pushExp(1'b1, 24'hABCDEF);
      applyStimulus(1'b1, 24'h123456, 1'b1, 24'hABCDEF);
      stepCycle();
      checkOutput("basic_l_valid", 32'(eng_valid), 1);
      checkOutput("basic_l_chan", 32'(eng_chan), 0);
      checkOutput("basic_l_data", 32'(eng_data), 32'h123456);
      stepCycle();
      checkOutput("basic_idle_valid", 32'(eng_valid), 0);
      stepCycle();
      checkOutput("basic_r_valid", 32'(eng_valid), 1);
      checkOutput("basic_r_chan", 32'(eng_chan), 1);
      checkOutput("basic_r_data", 32'(eng_data), 32'hABCDEF);
      stepCycle();
      checkOutput("basic_frame_done", 32'(frame_done), 1);
      waitDrain("basic", 20);

      // Backpressure: engine stalls for 20 cycles during SEND_L
      eng_ready = 1'b0;
      pushExp(1'b0, 24'h0F0F0F);
      pushExp(1'b1, 24'h707070);
      applyStimulus(1'b1, 24'h0F0F0F, 1'b1, 24'h707070);
      stepCycle();
      repeat (20) stepCycle();
      checkOutput("bp_valid", 32'(eng_valid), 1);
      checkOutput("bp_chan", 32'(eng_chan), 0);
      checkOutput("bp_data", 32'(eng_data), 32'h0F0F0F);
      eng_ready = 1'b1;
      waitDrain("bp", 30);

      // Same-edge capture: a new L arrives on the WAIT_L->SEND_L edge
      pushExp(1'b0, 24'h000010);
      pushExp(1'b1, 24'h000020);
      pushExp(1'b0, 24'h000030);
      applyStimulus(1'b1, 24'h000010, 1'b1, 24'h000020);
      applyStimulus(1'b1, 24'h000030, 1'b0, '0);
      checkOutput("same_edge_no_ovr", 32'(overrun), 0);
      repeat (4) stepCycle();
      pushExp(1'b1, 24'h000040);
      applyStimulus(1'b0, '0, 1'b1, 24'h000040);
      waitDrain("same_edge", 30);
      checkOutput("same_edge_no_ovr_end", 32'(overrun), 0);

      // Overrun: three L pulses against a stalled engine
      eng_ready = 1'b0;
      pushExp(1'b0, 24'h000001);
      applyStimulus(1'b1, 24'h000001, 1'b0, '0);
      stepCycle();
      applyStimulus(1'b1, 24'h000002, 1'b0, '0);
      stepCycle();
      checkOutput("ovr_before_third", 32'(overrun), 0);
      applyStimulus(1'b1, 24'h000003, 1'b0, '0);
      checkOutput("ovr_set", 32'(overrun), 1);
      checkOutput("ovr_out_data", 32'(eng_data), 32'h1);
      checkOutput("ovr_out_valid", 32'(eng_valid), 1);
      pushExp(1'b1, 24'h000055);
      pushExp(1'b0, 24'h000003);
      pushExp(1'b1, 24'h000066);
      applyStimulus(1'b0, '0, 1'b1, 24'h000055);
      eng_ready = 1'b1;
      n = 0;
      while (exp_q.size() > 2 && n < 40) begin
         stepCycle();
         n++;
      end
      checkOutput("ovr_r55_sent", exp_q.size(), 2);
      applyStimulus(1'b0, '0, 1'b1, 24'h000066);
      waitDrain("ovr", 40);
      checkOutput("ovr_sticky", 32'(overrun), 1);

      // Flush: drop run while R is being offered
      eng_ready = 1'b0;
      pushExp(1'b0, 24'h000077);
      applyStimulus(1'b1, 24'h000077, 1'b1, 24'h000088);
      stepCycle();
      eng_ready = 1'b1;
      stepCycle();
      eng_ready = 1'b0;
      stepCycle();
      checkOutput("flush_r_valid", 32'(eng_valid), 1);
      checkOutput("flush_r_chan", 32'(eng_chan), 1);
      checkOutput("flush_r_data", 32'(eng_data), 32'h88);
      run = 1'b0;
      stepCycle();
      checkOutput("flush_valid_low", 32'(eng_valid), 0);
      checkOutput("flush_no_frame_done", 32'(frame_done), 0);
      checkOutput("flush_ovr_kept", 32'(overrun), 1);
      run = 1'b1;
      repeat (3) stepCycle();
      checkOutput("flush_stays_idle", 32'(eng_valid), 0);
      checkOutput("flush_queue_empty", exp_q.size(), 0);
      eng_ready = 1'b1;
      pushExp(1'b0, 24'h000099);
      pushExp(1'b1, 24'h0000AA);
      applyStimulus(1'b1, 24'h000099, 1'b1, 24'h0000AA);
      waitDrain("post_flush", 30);

      // Overrun clear
      ovr_clear = 1'b1;
      stepCycle();
      ovr_clear = 1'b0;
      checkOutput("ovr_cleared", 32'(overrun), 0);

      // Randomized frames with random engine backpressure
      rand_ready = 1'b1;
      for (int f = 0; f < 40; f++) begin
         ld = DATA_W'($urandom);
         rd = DATA_W'($urandom);
         dl = $urandom_range(0, 3);
         dr = $urandom_range(0, 3);
         pushExp(1'b0, ld);
         pushExp(1'b1, rd);
         for (int k = 0; k < 4; k++) begin
            applyStimulus(k == dl, ld, k == dr, rd);
         end
         waitDrain("rand", 300);
      end
      rand_ready = 1'b0;
      eng_ready  = 1'b0;
      checkOutput("rand_no_overrun", 32'(overrun), 0);

      // Reset clears everything, including a pending sample and overrun
      pushExp(1'b0, 24'h0000C1);
      applyStimulus(1'b1, 24'h0000C1, 1'b0, '0);
      applyStimulus(1'b1, 24'h0000C2, 1'b0, '0);
      applyStimulus(1'b1, 24'h0000C3, 1'b0, '0);
      checkOutput("final_ovr_set", 32'(overrun), 1);
      void'(exp_q.pop_front());
      run   = 1'b0;
      reset = 1'b1;
      repeat (2) stepCycle();
      reset = 1'b0;
      stepCycle();
      checkOutput("final_rst_overrun", 32'(overrun), 0);
      checkOutput("final_rst_valid", 32'(eng_valid), 0);
      checkOutput("final_rst_data", 32'(eng_data), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
